// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, single-outstanding imem handshake and IF/ID register
// Redirects kill in-flight fetches; responses arriving under stall wait in a one-entry hold buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;

  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc4;
  logic [31:0] req_pc4;

  assign req_pc4   = req_pc_q + 32'd4;
  assign imem_req  = (state_q == S_REQ) && !reset;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc4    = id_pc4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    load         = 1'b0;
    load_instr   = imem_rdata;
    load_pc4     = req_pc4;

    case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          req_pc_d = pc_q;
          kill_d   = branch_taken;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
          // A redirect in the response cycle makes this response stale as well.
          if (!kill_q && !branch_taken) begin
            pc_d = req_pc4;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = req_pc4;
              state_d      = S_HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end else if (branch_taken) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          state_d = S_REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = hold_instr_q;
          load_pc4   = hold_pc4_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (branch_taken) begin
      pc_d = branch_target;
    end

    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    if (flush) begin
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
      id_pc4_d   = 32'h0;
    end else if (load) begin
      id_valid_d = 1'b1;
      id_instr_d = load_instr;
      id_pc4_d   = load_pc4;
    end else if (!stall) begin
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      kill_q       <= 1'b0;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0;
      id_pc4_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage against a transaction-level fetch model
// Memory returns addr+0x100 after a chosen latency; the model tracks in-flight, stale and parked fetches.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr, id_pc4;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc4       (id_pc4)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_instr, m_pc4, raddr, p_instr, p_pc4;
  logic        m_valid, busy, pend, stale;
  int          mem_wait;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    busy = 1'b0; pend = 1'b0; stale = 1'b0; mem_wait = 0;
    raddr = 32'h0; p_instr = 32'h0; p_pc4 = 32'h0;
  endtask

  task automatic drive_idle();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   {31'b0, imem_req}, 32'h0);
    check_eq({tag, "_addr"},  imem_addr, 32'h0);
    check_eq({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
    check_eq({tag, "_instr"}, id_instr, 32'h0);
    check_eq({tag, "_pc4"},   id_pc4, 32'h0);
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model across the next edge.
  task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t,
                      input logic rdy, input int lat);
    logic        acc, ld, resp;
    logic [31:0] ld_i, ld_p, old_pc;
    @(negedge clk);
    check_eq("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    check_eq("id_instr", id_instr, m_instr);
    if (m_valid) check_eq("id_pc4", id_pc4, m_pc4);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, (!busy && !pend)});
    check_eq("imem_addr", imem_addr, m_pc);

    resp = 1'b0;
    if (busy) begin
      mem_wait--;
      resp = (mem_wait == 0);
    end
    stall = s; flush = f; branch_taken = b; branch_target = t; imem_ready = rdy;
    imem_rvalid = resp;
    imem_rdata  = resp ? raddr + 32'h100 : $urandom;

    acc = !busy && !pend && rdy;
    old_pc = m_pc;
    ld = 1'b0; ld_i = 32'h0; ld_p = 32'h0;
    if (resp) begin
      busy = 1'b0;
      if (!stale && !b) begin
        m_pc = raddr + 32'd4;
        if (s) begin
          pend = 1'b1; p_instr = raddr + 32'h100; p_pc4 = raddr + 32'd4;
        end else begin
          ld = 1'b1; ld_i = raddr + 32'h100; ld_p = raddr + 32'd4;
        end
      end
    end else if (pend) begin
      if (b) pend = 1'b0;
      else if (!s) begin
        ld = 1'b1; ld_i = p_instr; ld_p = p_pc4; pend = 1'b0;
      end
    end
    if (b) m_pc = t;

    if (f) begin
      m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    end else if (ld) begin
      m_valid = 1'b1; m_instr = ld_i; m_pc4 = ld_p;
    end else if (!s) begin
      m_valid = 1'b0; m_instr = 32'h0;
    end

    if (acc) begin
      busy = 1'b1; raddr = old_pc; stale = b; mem_wait = lat;
    end else if (busy && b) begin
      stale = 1'b1;
    end
  endtask

  task automatic do_async_reset();
    #2;
    drive_idle();
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    drive_idle();
    reset = 1'b1;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4);
    if (busy) do_async_reset();
    else check_eq("async_setup_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);

    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           tgt, $urandom_range(0, 9) < 7, $urandom_range(1, 4));
      if ((i % 700) == 350 && busy) do_async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
